// File: rtl/glyph_rom_arbiter_pkg.sv
// Shared definitions for the glyph ROM arbiter: glyph row addresses and FSM states.
package glyph_rom_arbiter_pkg;

    // Glyph rows are stored as digits 0..9 followed by the blank glyph 'a'.
    localparam int unsigned CHAR_HEIGHT = 16;
    localparam int unsigned CHAR_A      = 10 * CHAR_HEIGHT;

    typedef enum logic {
        GARB_IDLE  = 1'b0,
        GARB_BURST = 1'b1
    } garb_state_e;

endpackage

// File: rtl/glyph_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module glyph_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   winner
);

    logic             done;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        done   = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
            if (!done && req[idx]) begin
                gnt[idx] = 1'b1;
                winner   = idx;
                done     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/glyph_rom_arbiter.sv
// Round-robin arbiter sharing one glyph ROM port among burst requesters.
// Define GLYPH_ARB_STATS_EN to add the saturating stall_cnt output.
module glyph_rom_arbiter
    import glyph_rom_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_adr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic [ADDR_W-1:0]         rom_adr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [LEN_W-1:0]          rsp_row,
    output logic [DATA_W-1:0]         rsp_data
`ifdef GLYPH_ARB_STATS_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    garb_state_e          state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d, id_q, id_d, winner;
    logic [LEN_W-1:0]     row_q, row_d, len_q, len_d;
    logic [ADDR_W-1:0]    adr_d;
    logic [NUM_REQ-1:0]   pick_gnt;

    logic [ROM_LAT-1:0]             pv_q;
    logic [ROM_LAT-1:0][PTR_W-1:0]  pid_q;
    logic [ROM_LAT-1:0][LEN_W-1:0]  prow_q;

    glyph_rr_pick #(
        .NUM_REQ(NUM_REQ),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .winner(winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GARB_IDLE;
            ptr_q   <= '0;
            row_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            rom_adr <= ADDR_W'(CHAR_A);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            row_q   <= row_d;
            len_q   <= len_d;
            id_q    <= id_d;
            rom_adr <= adr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        row_d   = row_q;
        len_d   = len_q;
        id_d    = id_q;
        adr_d   = rom_adr;
        gnt     = '0;
        case (state_q)
            GARB_IDLE: begin
                if (|req) begin
                    gnt     = pick_gnt;
                    len_d   = req_len[winner*LEN_W +: LEN_W];
                    id_d    = winner;
                    adr_d   = req_adr[winner*ADDR_W +: ADDR_W];
                    row_d   = '0;
                    state_d = GARB_BURST;
                    ptr_d   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
                end
            end
            GARB_BURST: begin
                if (row_q == len_q) begin
                    adr_d   = ADDR_W'(CHAR_A);
                    row_d   = '0;
                    state_d = GARB_IDLE;
                end else begin
                    adr_d = rom_adr + ADDR_W'(1);
                    row_d = row_q + LEN_W'(1);
                end
            end
            default: state_d = GARB_IDLE;
        endcase
    end

    assign busy = (state_q == GARB_BURST);

    // Tag travels alongside the ROM read so it lines up with rom_data ROM_LAT cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q   <= '0;
            pid_q  <= '0;
            prow_q <= '0;
        end else begin
            pv_q[0]   <= busy;
            pid_q[0]  <= busy ? id_q  : '0;
            prow_q[0] <= busy ? row_q : '0;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                pv_q[i]   <= pv_q[i-1];
                pid_q[i]  <= pid_q[i-1];
                prow_q[i] <= prow_q[i-1];
            end
        end
    end

    assign rsp_valid = pv_q[ROM_LAT-1] ? (NUM_REQ'(1) << pid_q[ROM_LAT-1]) : '0;
    assign rsp_row   = prow_q[ROM_LAT-1];
    assign rsp_data  = rom_data;

`ifdef GLYPH_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((|req) && !(|gnt) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Directed bench for glyph_rom_arbiter; stall_cnt checks active with GLYPH_ARB_STATS_EN.
module tb_glyph_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [39:0] req_adr = '0;
    logic [15:0] req_len = '0;
    logic [3:0]  gnt;
    logic        busy;
    logic [9:0]  rom_adr;
    logic [31:0] rom_data = '0;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_row;
    logic [31:0] rsp_data;
`ifdef GLYPH_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [9:0] BLANK = 10'd160;

    glyph_rom_arbiter #(
        .NUM_REQ(4),
        .ADDR_W (10),
        .DATA_W (32),
        .LEN_W  (4),
        .ROM_LAT(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_adr  (req_adr),
        .req_len  (req_len),
        .gnt      (gnt),
        .busy     (busy),
        .rom_adr  (rom_adr),
        .rom_data (rom_data),
        .rsp_valid(rsp_valid),
        .rsp_row  (rsp_row),
        .rsp_data (rsp_data)
`ifdef GLYPH_ARB_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return {6'h15, a, 6'h2a, ~a};
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_adr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned id, input logic [9:0] adr, input logic [3:0] len);
        req[id]              = 1'b1;
        req_adr[id*10 +: 10] = adr;
        req_len[id*4 +: 4]   = len;
    endtask

    // Called in the grant cycle; returns in the first cycle a new grant may appear.
    task automatic run_burst(input int unsigned id, input logic [9:0] base,
                             input int unsigned len, input bit drop);
        logic [9:0] ea;
        for (int unsigned j = 1; j <= len + 2; j++) begin
            step();
            if (j == 1 && drop) req = '0;
            #1;
            if (j <= len + 1) begin
                ea = base + 10'(j - 1);
                chk($sformatf("adr%0d", j), rom_adr, ea);
                chk("busy", busy, 1'b1);
                chk("nognt", gnt, 4'b0);
            end else begin
                chk("adr_end", rom_adr, BLANK);
                chk("busy_end", busy, 1'b0);
            end
            if (j >= 2) begin
                ea = base + 10'(j - 2);
                chk("rsp_v", rsp_valid, 4'b1 << id);
                chk("rsp_row", rsp_row, 4'(j - 2));
                chk("rsp_dat", rsp_data, rom_word(ea));
            end else begin
                chk("rsp_v0", rsp_valid, 4'b0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned order [5] = '{0, 1, 2, 3, 0};

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_adr", rom_adr, BLANK);
        chk("rst_gnt", gnt, 4'b0);
        chk("rst_rspv", rsp_valid, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_row", rsp_row, 4'b0);

        // Contention: all requesters, single-row bursts, strict rotation
        for (int unsigned i = 0; i < 4; i++) set_req(i, 10'(100 + i * 20), 4'd0);
        for (int unsigned n = 0; n < 5; n++) begin
            #1;
            chk($sformatf("rot%0d", n), gnt, 4'b1 << order[n]);
            run_burst(order[n], 10'(100 + order[n] * 20), 0, n == 4);
        end
        #1 chk("rot_idle", gnt, 4'b0);

        // Single burst
        step();
        set_req(1, 10'd40, 4'd9);
        #1 chk("single_gnt", gnt, 4'b0010);
        run_burst(1, 10'd40, 9, 1'b1);

        // Address wrap
        step();
        set_req(0, 10'd1022, 4'd3);
        #1 chk("wrap_gnt", gnt, 4'b0001);
        run_burst(0, 10'd1022, 3, 1'b1);

        // Reset mid-burst
        step();
        set_req(3, 10'd500, 4'd9);
        #1 chk("mid_gnt", gnt, 4'b1000);
        step();
        req = '0;
        repeat (3) step();
        chk("mid_adr3", rom_adr, 10'd503);
        rst = 1'b1;
        step();
        chk("mid_rspv", rsp_valid, 4'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_adr", rom_adr, BLANK);
        rst = 1'b0;
        for (int unsigned k = 0; k < 2; k++) begin
            step();
            chk("mid_quiet", rsp_valid, 4'b0);
        end
        set_req(2, 10'd60, 4'd1);
        #1 chk("post_gnt", gnt, 4'b0100);
        run_burst(2, 10'd60, 1, 1'b1);

        // Withdraw during another burst, plus stall statistics
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
`ifdef GLYPH_ARB_STATS_EN
        #1 chk("stall_rst", stall_cnt, 16'd0);
`endif
        set_req(0, 10'd200, 4'd3);
        #1 chk("wd_gnt0", gnt, 4'b0001);
        for (int unsigned j = 1; j <= 6; j++) begin
            step();
            if (j == 1) begin
                req = '0;
                set_req(2, 10'd300, 4'd2);
            end
            if (j == 3) req[2] = 1'b0;
            #1;
            chk($sformatf("wd_gnt%0d", j), gnt, 4'b0);
            chk("wd_rsp2", rsp_valid[2], 1'b0);
            if (j == 5) chk("wd_busy", busy, 1'b0);
`ifdef GLYPH_ARB_STATS_EN
            if (j == 2) chk("stall1", stall_cnt, 16'd1);
            if (j == 6) chk("stall2", stall_cnt, 16'd2);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
